// File: rtl/alu_sequencer.sv
// Two-cycle (FETCH/EXEC) control unit that drives an external 8-bit ALU.
// It executes ALU ops, load-immediate, conditional branch and halt out of a byte-wide program ROM.
`timescale 1ns/1ps

module alu_sequencer #(
    parameter logic [7:0] START_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_data,
    output logic [1:0] ins_sel,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_result,
    input  logic       alu_co,
    input  logic       alu_z,
    output logic       busy,
    output logic       halted,
    output logic       c_flag,
    output logic       z_flag,
    input  logic [1:0] dbg_sel,
    output logic [7:0] dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t     r_state;
    state_t     w_stateNext;
    logic [7:0] r_pc;
    logic [7:0] w_pcNext;
    logic [7:0] r_ir;
    logic [7:0] w_irNext;
    logic [7:0] r_regs [4];
    logic       r_c;
    logic       r_z;
    logic       w_regWe;
    logic [1:0] w_regIdx;
    logic [7:0] w_regData;
    logic       w_flagWe;
    logic       w_brTaken;

    // The ALU is fed straight from ir in every state, so its inputs are stable throughout EXEC.
    assign imem_addr = r_pc;
    assign ins_sel   = r_ir[5:4];
    assign alu_a     = r_regs[r_ir[3:2]];
    assign alu_b     = r_regs[r_ir[1:0]];
    assign busy      = (r_state == S_FETCH) || (r_state == S_EXEC);
    assign halted    = (r_state == S_HALT);
    assign c_flag    = r_c;
    assign z_flag    = r_z;
    assign dbg_data  = r_regs[dbg_sel];

    always_comb begin
        w_brTaken = 1'b0;
        case (r_ir[5:4])
            2'b00: w_brTaken = 1'b1;
            2'b01: w_brTaken = r_z;
            2'b10: w_brTaken = r_c;
            2'b11: w_brTaken = !r_z;
            default: w_brTaken = 1'b0;
        endcase
    end

    always_comb begin
        w_stateNext = r_state;
        w_pcNext    = r_pc;
        w_irNext    = r_ir;
        w_regWe     = 1'b0;
        w_regIdx    = r_ir[3:2];
        w_regData   = alu_result;
        w_flagWe    = 1'b0;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    w_pcNext    = START_PC;
                    w_stateNext = S_FETCH;
                end
            end
            S_FETCH: begin
                w_irNext    = imem_data;
                w_pcNext    = r_pc + 8'd1;
                w_stateNext = S_EXEC;
            end
            S_EXEC: begin
                w_stateNext = S_FETCH;
                case (r_ir[7:6])
                    2'b00: begin
                        w_regWe  = 1'b1;
                        w_flagWe = 1'b1;
                    end
                    2'b01: begin
                        w_regWe   = 1'b1;
                        w_regIdx  = r_ir[5:4];
                        w_regData = imem_data;
                        w_pcNext  = r_pc + 8'd1;
                    end
                    2'b10: begin
                        w_pcNext = w_brTaken ? imem_data : r_pc + 8'd1;
                    end
                    default: begin
                        if (r_ir[5]) begin
                            w_stateNext = S_HALT;
                        end
                    end
                endcase
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= START_PC;
            r_ir    <= 8'h00;
            r_c     <= 1'b0;
            r_z     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            r_state <= w_stateNext;
            r_pc    <= w_pcNext;
            r_ir    <= w_irNext;
            if (w_regWe) begin
                r_regs[w_regIdx] <= w_regData;
            end
            if (w_flagWe) begin
                r_c <= alu_co;
                r_z <= alu_z;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: behavioural ALU and program ROM around the DUT,
// with hand-computed register, flag, pc and timing expectations.
`timescale 1ns/1ps

module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic [1:0] ins_sel;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_result;
    logic       alu_co;
    logic       alu_z;
    logic       busy;
    logic       halted;
    logic       c_flag;
    logic       z_flag;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] rom [256];

    always #5 clk = ~clk;

    alu_sequencer #(.START_PC(8'h00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .ins_sel    (ins_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_co     (alu_co),
        .alu_z      (alu_z),
        .busy       (busy),
        .halted     (halted),
        .c_flag     (c_flag),
        .z_flag     (z_flag),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    assign imem_data = rom[imem_addr];

    // Reference ALU: CLS rotates left and reports the bit shifted out as carry.
    always_comb begin
        alu_result = 8'h00;
        alu_co     = 1'b0;
        case (ins_sel)
            2'b00: alu_result = alu_a & alu_b;
            2'b01: alu_result = alu_a ^ alu_b;
            2'b10: {alu_co, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            default: begin
                alu_result = {alu_a[6:0], alu_a[7]};
                alu_co     = alu_a[7];
            end
        endcase
        alu_z = (alu_result == 8'h00);
    end

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic checkReg(input string tag, input logic [1:0] sel, input logic [7:0] exp);
        dbg_sel = sel;
        #1;
        checkOutput(tag, dbg_data, exp);
    endtask

    task automatic clearRom();
        for (int i = 0; i < 256; i++) begin
            rom[i] = 8'hE0;
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle start pulse; returns at the negedge after the edge that enters FETCH.
    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic doReset(input string tag);
        rst_n = 1'b0;
        #1;
        checkOutput({tag, "_busy"}, {7'd0, busy}, 8'h00);
        checkOutput({tag, "_halted"}, {7'd0, halted}, 8'h00);
        checkOutput({tag, "_pc"}, imem_addr, 8'h00);
        checkOutput({tag, "_flags"}, {6'd0, c_flag, z_flag}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            checkReg({tag, "_reg"}, 2'(i), 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic waitHalt(input string tag, input int maxCycles);
        int n;
        n = 0;
        while (!halted && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_halt_reached"}, {7'd0, halted}, 8'h01);
    endtask

    task automatic loadAddProgram();
        clearRom();
        rom[0] = 8'h40; rom[1] = 8'h05;
        rom[2] = 8'h50; rom[3] = 8'h03;
        rom[4] = 8'h21;
        rom[5] = 8'hE0;
    endtask

    initial begin
        rst_n   = 1'b1;
        start   = 1'b0;
        dbg_sel = 2'd0;
        #3;

        $display("[TB] basic ADD program with exact timing");
        loadAddProgram();
        doReset("rst");
        applyStimulus();
        stepCycles(7);
        checkOutput("t1_halted_early", {7'd0, halted}, 8'h00);
        checkOutput("t1_busy_early", {7'd0, busy}, 8'h01);
        stepCycles(1);
        checkOutput("t1_halted", {7'd0, halted}, 8'h01);
        checkOutput("t1_busy", {7'd0, busy}, 8'h00);
        checkReg("t1_r0", 2'd0, 8'h08);
        checkReg("t1_r1", 2'd1, 8'h03);
        checkOutput("t1_c", {7'd0, c_flag}, 8'h00);
        checkOutput("t1_z", {7'd0, z_flag}, 8'h00);
        checkOutput("t1_pc", imem_addr, 8'h06);

        $display("[TB] ADD with carry, LDI keeps flags, restart keeps registers");
        clearRom();
        rom[0] = 8'h60; rom[1] = 8'hF0;
        rom[2] = 8'h70; rom[3] = 8'h20;
        rom[4] = 8'h2B;
        rom[5] = 8'h40; rom[6] = 8'h00;
        rom[7] = 8'hE0;
        doReset("t2rst");
        applyStimulus();
        waitHalt("t2", 40);
        checkReg("t2_r2", 2'd2, 8'h10);
        checkReg("t2_r0", 2'd0, 8'h00);
        checkOutput("t2_c", {7'd0, c_flag}, 8'h01);
        checkOutput("t2_z", {7'd0, z_flag}, 8'h00);
        checkOutput("t2_pc", imem_addr, 8'h08);
        clearRom();
        rom[0] = 8'h2B;
        rom[1] = 8'hE0;
        applyStimulus();
        waitHalt("t2b", 10);
        checkReg("t2b_r2", 2'd2, 8'h30);
        checkOutput("t2b_c", {7'd0, c_flag}, 8'h00);
        checkOutput("t2b_pc", imem_addr, 8'h02);

        $display("[TB] AND to zero then taken BR Z");
        clearRom();
        rom[0] = 8'h40; rom[1] = 8'h0F;
        rom[2] = 8'h50; rom[3] = 8'hF0;
        rom[4] = 8'h01;
        rom[5] = 8'h90; rom[6] = 8'h20;
        rom[7] = 8'h70; rom[8] = 8'hAA;
        rom[9] = 8'hE0;
        rom[8'h20] = 8'hE0;
        doReset("t3rst");
        applyStimulus();
        stepCycles(8);
        checkOutput("t3_target_pc", imem_addr, 8'h20);
        checkOutput("t3_busy", {7'd0, busy}, 8'h01);
        waitHalt("t3", 10);
        checkOutput("t3_z", {7'd0, z_flag}, 8'h01);
        checkReg("t3_r0", 2'd0, 8'h00);
        checkReg("t3_r3", 2'd3, 8'h00);
        checkOutput("t3_pc", imem_addr, 8'h21);

        $display("[TB] CLS rotate");
        clearRom();
        rom[0] = 8'h50; rom[1] = 8'h81;
        rom[2] = 8'h35;
        rom[3] = 8'hE0;
        doReset("t4rst");
        applyStimulus();
        waitHalt("t4", 20);
        checkReg("t4_r1", 2'd1, 8'h03);
        checkOutput("t4_c", {7'd0, c_flag}, 8'h01);
        checkOutput("t4_z", {7'd0, z_flag}, 8'h00);
        clearRom();
        rom[0] = 8'h50; rom[1] = 8'h81;
        for (int i = 2; i < 10; i++) begin
            rom[i] = 8'h35;
        end
        rom[10] = 8'hE0;
        doReset("t4brst");
        applyStimulus();
        waitHalt("t4b", 40);
        checkReg("t4b_r1", 2'd1, 8'h81);
        checkOutput("t4b_c", {7'd0, c_flag}, 8'h01);
        checkOutput("t4b_pc", imem_addr, 8'h0B);

        $display("[TB] countdown loop with BR NZ");
        clearRom();
        rom[0] = 8'h40; rom[1] = 8'h03;
        rom[2] = 8'h50; rom[3] = 8'hFF;
        rom[4] = 8'h21;
        rom[5] = 8'hB0; rom[6] = 8'h04;
        rom[7] = 8'hE0;
        doReset("t5rst");
        applyStimulus();
        stepCycles(16);
        checkOutput("t5_fallthrough_pc", imem_addr, 8'h07);
        stepCycles(1);
        checkOutput("t5_halted_early", {7'd0, halted}, 8'h00);
        stepCycles(1);
        checkOutput("t5_halted", {7'd0, halted}, 8'h01);
        checkReg("t5_r0", 2'd0, 8'h00);
        checkOutput("t5_z", {7'd0, z_flag}, 8'h01);
        checkOutput("t5_c", {7'd0, c_flag}, 8'h01);
        checkOutput("t5_pc", imem_addr, 8'h08);

        $display("[TB] start ignored during EXEC");
        loadAddProgram();
        doReset("t6rst");
        applyStimulus();
        stepCycles(1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("t6_pc_no_restart", imem_addr, 8'h02);
        waitHalt("t6", 20);
        checkReg("t6_r0", 2'd0, 8'h08);

        $display("[TB] reset during ALU EXEC");
        doReset("t7pre");
        applyStimulus();
        stepCycles(5);
        checkOutput("t7_in_exec", {7'd0, busy}, 8'h01);
        doReset("t7rst");
        stepCycles(3);
        checkOutput("t7_idle_busy", {7'd0, busy}, 8'h00);
        checkReg("t7_r0_after", 2'd0, 8'h00);
        checkOutput("t7_pc_after", imem_addr, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Sequential control unit that drives the team's 8-bit combinational ALU: it fetches 8-bit instructions from an external program ROM, presents operands and the 2-bit operation select to the ALU, and writes the result and carry/zero flags back into a four-entry register file. It also executes load-immediate, conditional-branch and halt instructions. It sits between the program memory and the ALU and is the only master of the ALU's select and operand inputs.

## Interface
- START_PC, 8'h00, PC value loaded on each `start`

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin execution at START_PC; honoured only in IDLE or HALT
- imem_addr  out  8  program address, always equal to pc
- imem_data  in  8  instruction/operand byte at imem_addr, combinational ROM, valid in the same cycle
- ins_sel  out  2  to ALU op select: 00 AND, 01 XOR, 10 ADD, 11 CLS (rotate A left by 1)
- alu_a, alu_b  out  8 each  to ALU operands
- alu_result  in  8  from ALU result
- alu_co, alu_z  in  1 each  from ALU carry and zero flags
- busy  out  1  high in FETCH and EXEC
- halted  out  1  high in HALT
- c_flag, z_flag  out  1 each  latched flags
- dbg_sel  in  2  register-file read select
- dbg_data  out  8  R[dbg_sel], combinational

## Operation
- State: pc[7:0], ir[7:0], R0–R3 (8 bits each), c_flag, z_flag, FSM {IDLE, FETCH, EXEC, HALT}.
- Reset values: IDLE; pc = START_PC; ir = 0; R0–R3 = 0; flags = 0; busy = 0; halted = 0.
- Encoding of ir:
  - [7:6]=00 ALU op: ins_sel=[5:4], rd=[3:2] (also source A), rs=[1:0] (source B).
  - [7:6]=01 LDI: rd=[5:4]; the next byte is the immediate.
  - [7:6]=10 BR: cond=[5:4] (00 always, 01 Z=1, 10 C=1, 11 Z=0); the next byte is the target.
  - [7:6]=11: [5]=1 HALT, [5]=0 NOP.
- Outputs alu_a = R[ir[3:2]], alu_b = R[ir[1:0]], ins_sel = ir[5:4] are driven continuously from ir in every state.
- IDLE/HALT: if start=1, load pc ← START_PC and go to FETCH. Registers and flags are kept across restarts.
- FETCH: ir ← imem_data; pc ← pc+1; go to EXEC.
- EXEC:
  - ALU op: R[rd] ← alu_result; c_flag ← alu_co; z_flag ← alu_z.
  - LDI: R[rd] ← imem_data; pc ← pc+1.
  - BR: if the condition is true, pc ← imem_data; otherwise pc ← pc+1. The condition uses flags latched before this instruction.
  - NOP: no state change.
  - After ALU op, LDI, BR or NOP: go to FETCH. HALT: go to HALT without changing pc.
- Only ALU ops modify flags.
- Arithmetic: pc is 8-bit and wraps from 0xFF to 0x00, including during operand fetch. Register writes are 8-bit; the carry comes solely from alu_co.
- `start` in FETCH/EXEC is ignored.
- rd = rs is legal: both operands are the same register, and the result overwrites it.

## Timing
- Every instruction takes 2 cycles: FETCH, then EXEC.
- An ALU op result is visible on dbg_data and the flags 2 edges after entering FETCH.
- A taken branch target is on imem_addr the cycle after EXEC. There is no delay slot.
- halted rises on the edge ending the EXEC of HALT. busy falls on the same edge.
- rst_n low at any time: asynchronously returns all state to its reset values, including mid-instruction. Partially executed instructions are discarded.
- start must be held for at least one rising edge. One edge in IDLE/HALT is sufficient.

## Test plan
- Program LDI R0,0x05; LDI R1,0x03; ADD R0,R1; HALT; start pulse → after 8 cycles halted=1, R0=0x08, c_flag=0, z_flag=0, pc=0x06.
- LDI R2,0xF0; LDI R3,0x20; ADD R2,R3 → R2=0x10, c_flag=1, z_flag=0. A following LDI leaves the flags unchanged.
- LDI R0,0x0F; LDI R1,0xF0; AND R0,R1; BR Z→0x20 with HALT at 0x20 → z_flag=1, pc=0x20 on the cycle after the branch EXEC, halted=1.
- LDI R1,0x81; CLS R1 → R1=0x03, c_flag=1 (carry equals result bit 0). Repeating until R1=0x81 takes 8 rotations.
- Countdown loop using XOR/ADD with a not-zero branch → branch taken N−1 times, falls through once, and the final pc is the branch address + 2.
- Robustness: assert start during EXEC → ignored. Drop rst_n during EXEC of an ALU op → R[rd] stays 0, state is IDLE, and busy=0 immediately.
